// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low g..a patterns, index 15 (F) first down to index 0.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment decode.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with blanking dead-time and
// a one-deep pending buffer that is applied only at frame boundaries.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DIGIT_TICKS = 100000,
  parameter int unsigned BLANK_TICKS = 1000
) (
  input  logic        CLK100MHZ,
  input  logic        BTNR,
  input  logic        wr_valid,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int unsigned MaxTicks = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int unsigned CntW     = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;

  localparam logic [CntW-1:0] BlankLast   = CntW'(BLANK_TICKS - 1);
  localparam logic [CntW-1:0] DigitLast   = CntW'(DIGIT_TICKS - 1);
  localparam logic [CntW-1:0] DigitPenult = CntW'(DIGIT_TICKS - 2);

  state_e          state_q;
  logic [1:0]      idx_q;
  logic [CntW-1:0] cnt_q;
  logic [15:0]     active_q;
  logic [15:0]     pend_q;
  logic            pend_full_q;

  logic [3:0]      nibble;
  logic [6:0]      seg_dec;
  logic            xfer;
  logic            frame_end;

  assign nibble    = active_q[{idx_q, 2'b00} +: 4];
  assign wr_ready  = ~pend_full_q;
  assign xfer      = wr_valid & wr_ready;
  // frame_done is only ever high on the final SHOW cycle of digit 3.
  assign frame_end = frame_done;

  hex7seg u_hex7seg (
    .hex (nibble),
    .seg (seg_dec)
  );

  always_ff @(posedge CLK100MHZ or negedge BTNR) begin
    if (!BTNR) begin
      state_q    <= BLANK;
      idx_q      <= 2'd0;
      cnt_q      <= '0;
      seg        <= SEG_BLANK;
      an         <= 4'hF;
      frame_done <= 1'b0;
    end else begin
      unique case (state_q)
        BLANK: begin
          if (cnt_q == BlankLast) begin
            state_q    <= SHOW;
            cnt_q      <= '0;
            an         <= ~(4'b0001 << idx_q);
            seg        <= seg_dec;
            frame_done <= (idx_q == 2'd3) && (DIGIT_TICKS == 1);
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        SHOW: begin
          if (cnt_q == DigitLast) begin
            state_q    <= BLANK;
            cnt_q      <= '0;
            idx_q      <= idx_q + 2'd1;
            an         <= 4'hF;
            seg        <= SEG_BLANK;
            frame_done <= 1'b0;
          end else begin
            cnt_q      <= cnt_q + CntW'(1);
            // Raise frame_done one edge early so it is a registered output.
            frame_done <= (idx_q == 2'd3) && (cnt_q == DigitPenult);
          end
        end
        default: begin
          state_q <= BLANK;
        end
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or negedge BTNR) begin
    if (!BTNR) begin
      active_q    <= 16'h0000;
      pend_q      <= 16'h0000;
      pend_full_q <= 1'b0;
    end else begin
      if (frame_end && pend_full_q) begin
        active_q    <= pend_q;
        pend_full_q <= 1'b0;
      end
      // A transfer needs an empty buffer, so it never collides with the copy above.
      if (xfer) begin
        pend_q      <= wr_data;
        pend_full_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench: a frame-arithmetic model pushes expected outputs each cycle,
// a monitor pops and compares them against the DUT on the falling edge.
module tb_seg_scan_ctrl;

  localparam int unsigned DT    = 4;
  localparam int unsigned BT    = 2;
  localparam int unsigned Slot  = DT + BT;
  localparam int unsigned Frame = 4 * Slot;

  logic        clk = 1'b0;
  logic        btnr;
  logic        wr_valid;
  logic [15:0] wr_data;
  logic        wr_ready;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];

  seg_scan_ctrl #(
    .DIGIT_TICKS (DT),
    .BLANK_TICKS (BT)
  ) dut (
    .CLK100MHZ  (clk),
    .BTNR       (btnr),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    case (h)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Reference model: t counts edges since reset release; a frame is 24 cycles
  // of four (blank, blank, lit x4) slots; words move pending->active at frame end.
  int unsigned t = 0;
  logic [15:0] m_active = 16'h0;
  logic [15:0] m_pend = 16'h0;
  logic        m_full = 1'b0;

  always @(posedge clk) begin
    exp_t e;
    int unsigned q;
    int unsigned k;
    logic fe;
    logic x;
    if (!btnr) begin
      t = 0;
      m_active = 16'h0;
      m_full = 1'b0;
    end else begin
      fe = ((t % Frame) == Frame - 1);
      x  = wr_valid && !m_full;
      if (fe && m_full) begin
        m_active = m_pend;
        m_full = 1'b0;
      end
      if (x) begin
        m_pend = wr_data;
        m_full = 1'b1;
      end
      t++;
    end
    q = t % Frame;
    k = q / Slot;
    e.an  = 4'hF;
    e.seg = 7'h7F;
    e.fd  = 1'b0;
    if ((q % Slot) >= BT) begin
      e.an  = ~(4'b0001 << k);
      e.seg = seg_of(m_active[k*4 +: 4]);
      e.fd  = (q == Frame - 1);
    end
    e.rdy = !m_full;
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({an, seg, frame_done, wr_ready} !== e) begin
        errors++;
        $display("FAIL cycle @%0t: got an=%h seg=%h fd=%b rdy=%b, want an=%h seg=%h fd=%b rdy=%b",
                 $time, an, seg, frame_done, wr_ready, e.an, e.seg, e.fd, e.rdy);
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      wr_data = 16'($urandom);
    end
  endtask

  // Called just after a falling edge; returns on the falling edge after acceptance.
  task automatic do_write(input logic [15:0] d);
    logic r;
    int n;
    n = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    forever begin
      r = wr_ready;
      @(negedge clk);
      if (r) break;
      n++;
      if (n > 200) begin
        errors++;
        $display("FAIL write-timeout: ready stayed 0, want 1 within 200 cycles");
        break;
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_neg(input logic [3:0] want_an, input logic want_fd, input string name);
    int n;
    n = 0;
    while (!((want_fd && frame_done && wr_ready) || (!want_fd && an == want_an))) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        errors++;
        $display("FAIL %s: event not seen, want it within 200 cycles", name);
        break;
      end
    end
  endtask

  initial begin
    btnr     = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 16'h0;
    #1 btnr  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_seg", {9'h0, seg}, 16'h007F);
    check("reset_an", {12'h0, an}, 16'h000F);
    check("reset_fd", {15'h0, frame_done}, 16'h0000);
    check("reset_ready", {15'h0, wr_ready}, 16'h0001);
    #1 btnr = 1'b1;

    idle(60);
    do_write(16'h3A91);
    idle(60);

    do_write(16'h1111);
    check("stall_ready", {15'h0, wr_ready}, 16'h0000);
    do_write(16'h2222);
    idle(60);

    wait_neg(4'h0, 1'b1, "wait_frame_done");
    do_write(16'hBEEF);
    idle(60);

    wait_neg(4'h0, 1'b1, "wait_frame_done2");
    @(negedge clk);
    do_write(16'hCAFE);
    wait_neg(4'hB, 1'b0, "wait_digit2");
    check("pending_full", {15'h0, wr_ready}, 16'h0000);
    #1 btnr = 1'b0;
    #1;
    check("midreset_an", {12'h0, an}, 16'h000F);
    check("midreset_seg", {9'h0, seg}, 16'h007F);
    check("midreset_ready", {15'h0, wr_ready}, 16'h0001);
    check("midreset_fd", {15'h0, frame_done}, 16'h0000);
    repeat (2) @(negedge clk);
    #1 btnr = 1'b1;
    idle(60);

    for (int i = 0; i < 25; i++) begin
      idle($urandom_range(0, 30));
      do_write(16'($urandom));
    end
    idle(60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
